// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM among NUM_PORTS requesters.
// Grants are combinational; locked bursts hold ownership for up to MAX_BURST accesses.
module ram_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wb,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_enable,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    output logic [DATA_WIDTH/8-1:0]          mem_wb,
    input  logic [DATA_WIDTH-1:0]            mem_data_out
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          owner_q;
    logic [7:0]             count_q;
    logic [NUM_PORTS-1:0]   rvalid_q;

    logic                   cont;
    logic                   search_hit;
    logic [PW-1:0]          search_idx;
    logic                   gnt_any;
    logic                   gnt_valid;
    logic [PW-1:0]          gnt_idx;
    logic [7:0]             count_d;
    logic [NUM_PORTS-1:0]   gnt_vec;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    assign cont = (state_q == LOCKED) && req[owner_q] && lock[owner_q] && (count_q < BURST_LIMIT);

    // The search starts just after the last winner, so the previous owner is checked last.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
        search_hit = 1'b0;
        search_idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!search_hit && req[rr_index(ptr_q, k)]) begin
                search_hit = 1'b1;
                search_idx = rr_index(ptr_q, k);
            end
        end
    end

    assign gnt_any   = cont | search_hit;
    assign gnt_idx   = cont ? owner_q : search_idx;
    assign gnt_valid = gnt_any & reset;
    assign count_d   = cont ? (count_q + 8'd1) : 8'd1;

    always_comb begin
        gnt_vec          = '0;
        gnt_vec[gnt_idx] = gnt_valid;
    end

    assign gnt         = gnt_vec;
    assign mem_enable  = gnt_valid;
    assign mem_addr    = gnt_valid ? addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign mem_data_in = gnt_valid ? wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mem_wb      = gnt_valid ? wb[gnt_idx*BE_WIDTH +: BE_WIDTH] : '0;

    assign rvalid = rvalid_q;
    assign rdata  = mem_data_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(NUM_PORTS - 1);
            owner_q  <= '0;
            count_q  <= '0;
            rvalid_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rvalid_q <= gnt_vec;
            if (gnt_any) begin
                ptr_q <= gnt_idx;
                if (lock[gnt_idx]) begin
                    state_q <= LOCKED;
                    owner_q <= gnt_idx;
                    count_q <= count_d;
                end else begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            end else begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port word RAM among NUM_PORTS requesters, for example the CPU fetch, CPU data, DMA and NoC packet buffer.
- Arbitration is round-robin, with optional locked bursts.
- Grants are combinational, so a granted access takes no extra cycle.
- The RAM's registered data_out comes back one cycle later, tagged with a per-port rvalid.
- Sits between the requesters and the RAM's memory interface.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_WIDTH, 11, word address width (2048-word RAM)
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_BURST, 8, maximum consecutive grants to one locked port (1..255)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_PORTS  access request per port, held until granted
lock  in  NUM_PORTS  port asks to keep ownership for back-to-back accesses
addr  in  NUM_PORTS*ADDR_WIDTH  per-port word address, port i at slice i
wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
wb  in  NUM_PORTS*DATA_WIDTH/8  per-port byte write enables; all zero means read
gnt  out  NUM_PORTS  one-hot grant; the access is accepted this cycle
rvalid  out  NUM_PORTS  one-hot; rdata belongs to this port this cycle
rdata  out  DATA_WIDTH  shared read return, wired from mem_data_out
mem_enable  out  1  RAM enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_data_in  out  DATA_WIDTH  RAM write data
mem_wb  out  DATA_WIDTH/8  RAM byte write enables
mem_data_out  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset state (reset=0):
  - state=IDLE, ptr=NUM_PORTS-1, owner=0, count=0, rvalid=0.
  - While reset is low, gnt, mem_enable and mem_wb are forced to 0, and mem_addr and mem_data_in to 0.
  - An access in flight when reset falls is abandoned; the RAM is not written.
- State machine, state is IDLE or LOCKED:
  - Continue rule: in LOCKED, if req[owner] && lock[owner] && count<MAX_BURST, then gnt[owner]=1.
  - Otherwise, search round-robin from (ptr+1) mod NUM_PORTS upward and grant the first port with req set.
  - Release happens in the same cycle as the search, with no idle bubble. This covers: owner dropping req, owner dropping lock, and count reaching MAX_BURST.
  - With no req set, gnt=0 and mem_enable=0.
- Register updates on each granted cycle:
  - ptr <= granted index.
  - If lock[granted]=1: state <= LOCKED, owner <= granted index, count <= (same owner continuing ? count+1 : 1).
  - If lock[granted]=0: state <= IDLE, count <= 0.
  - A cycle with no grant sets state <= IDLE.
- Burst limit:
  - A burst-limited owner that still asserts lock can win the next round-robin search only if it is the sole requester.
  - Such a win starts a new burst with count=1.
- Datapath:
  - mem_enable = |gnt.
  - mem_addr, mem_data_in and mem_wb are the granted port's slices, all-zero when there is no grant.
  - Selection is pure combinational mux, with no latency added.
- Return path:
  - rvalid <= gnt, registered.
  - rdata = mem_data_out, so data is valid in the cycle after the grant.
  - Every granted access, read or write, produces exactly one rvalid pulse.
  - For a write, rdata is the pre-write word, because the RAM reads before it writes.
- Requester rule: addr, wdata and wb must stay stable while req=1 and gnt=0. The arbiter never queues requests.
- Latency: grant in cycle N, data in cycle N+1. Sustained throughput is 1 access per cycle.

Test Plan:
1. Only port 0 reads addr 0x010, RAM word 0x0000CAFE -> gnt=0001 in that cycle; next cycle rvalid=0001, rdata=0x0000CAFE.
2. All four ports hold req=1, lock=0, starting from reset -> grant order 0,1,2,3,0,1; one rvalid per grant, lagging by one cycle; mem_enable stays 1.
3. Port 2 has req=lock=1, port 1 has req=1, MAX_BURST=8 -> gnt[2] for 8 consecutive cycles, then gnt[1] in cycle 9, then gnt[2] again in cycle 10 with count=1.
4. Addr 5 holds 0x11223344; port 3 writes wb=0100, wdata=0xAABBCCDD -> write-cycle rvalid[3] returns 0x11223344; a later read of addr 5 returns 0x11BB3344.
5. Port 1 locked with ports 0 and 3 requesting; port 1 drops lock after 3 grants -> the next cycle grants port 3 (round-robin from 2) with no bubble, then port 0.
6. reset driven low mid-burst -> gnt, mem_enable and rvalid go 0 immediately, with no clock edge needed; after release with all ports requesting, port 0 is granted first.
